// File: rtl/mem_access_sequencer.sv
// Load/store sequencer in front of datamemory.
// Splits misaligned accesses and extends load results.
module mem_access_sequencer #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  dm_MemRead,
    output logic                  dm_MemWrite,
    output logic [DM_ADDRESS-1:0] dm_a,
    output logic [DATA_W-1:0]     dm_wd,
    output logic [2:0]            dm_Funct3,
    input  logic [DATA_W-1:0]     dm_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_LO,
        S_LD_HI,
        S_ST_ALN,
        S_ST_BYTE
    } state_t;

    localparam logic [2:0] F3_B = 3'b000;
    localparam logic [2:0] F3_W = 3'b010;

    state_t                  r_state;
    logic [2:0]              r_funct3;
    logic [DM_ADDRESS-1:0]   r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic                    r_mis;
    logic [1:0]              r_k;
    logic [DATA_W-1:0]       r_lo;
    logic [DATA_W-1:0]       r_hi;
    logic                    r_rsp_valid;
    logic [DATA_W-1:0]       r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_rd;
    logic                    r_wr;
    logic [DM_ADDRESS-1:0]   r_dm_a;
    logic [DATA_W-1:0]       r_dm_wd;
    logic [2:0]              r_dm_f3;

    logic                    w_bad;
    logic                    w_mis;
    logic [DM_ADDRESS-1:0]   w_req_w0;
    logic [DM_ADDRESS-1:0]   w_cw0;
    logic [DM_ADDRESS-1:0]   w_cw1;
    logic [1:0]              w_k_next;
    logic [1:0]              w_k_last;
    logic [DM_ADDRESS-1:0]   w_byte_addr;
    logic [7:0]              w_byte;
    logic [DATA_W-1:0]       w_lo;
    logic [DATA_W-1:0]       w_hi;
    logic [2*DATA_W-1:0]     w_pair;
    logic [DATA_W-1:0]       w_sh;
    logic [DATA_W-1:0]       w_ld_res;

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign dm_MemRead  = r_rd;
    assign dm_MemWrite = r_wr;
    assign dm_a        = r_dm_a;
    assign dm_wd       = r_dm_wd;
    assign dm_Funct3   = r_dm_f3;

    assign w_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                || (req_write && req_funct3[2]);
    assign w_mis = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    assign w_req_w0 = {req_addr[DM_ADDRESS-1:2], 2'b00};
    assign w_cw0    = {r_addr[DM_ADDRESS-1:2], 2'b00};
    assign w_cw1    = w_cw0 + DM_ADDRESS'(4);

    // Byte-split stores walk k upward; addresses wrap at the top of memory.
    assign w_k_next    = r_k + 2'd1;
    assign w_k_last    = (r_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
    assign w_byte_addr = r_addr + DM_ADDRESS'(w_k_next);
    assign w_byte      = r_wdata[{w_k_next, 3'b000} +: 8];

    assign w_lo   = (r_state == S_LD_LO) ? dm_rd : r_lo;
    assign w_hi   = (r_state == S_LD_HI) ? dm_rd : r_hi;
    assign w_pair = {w_hi, w_lo};
    assign w_sh   = DATA_W'(w_pair >> {r_addr[1:0], 3'b000});

    always_comb begin
        w_ld_res = w_sh;
        unique case (r_funct3)
            3'b000:  w_ld_res = {{24{w_sh[7]}}, w_sh[7:0]};
            3'b001:  w_ld_res = {{16{w_sh[15]}}, w_sh[15:0]};
            3'b100:  w_ld_res = {24'h0, w_sh[7:0]};
            3'b101:  w_ld_res = {16'h0, w_sh[15:0]};
            default: w_ld_res = w_sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mis       <= 1'b0;
            r_k         <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_dm_a      <= '0;
            r_dm_wd     <= '0;
            r_dm_f3     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_bad) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_funct3 <= req_funct3;
                            r_addr   <= req_addr;
                            r_wdata  <= req_wdata;
                            r_mis    <= w_mis;
                            r_k      <= '0;
                            r_hi     <= '0;
                            if (!req_write) begin
                                r_state <= S_LD_LO;
                                r_rd    <= 1'b1;
                                r_dm_a  <= w_req_w0;
                                r_dm_f3 <= F3_W;
                            end else if (!w_mis) begin
                                r_state <= S_ST_ALN;
                                r_wr    <= 1'b1;
                                r_dm_a  <= req_addr;
                                r_dm_wd <= req_wdata;
                                r_dm_f3 <= req_funct3;
                            end else begin
                                r_state <= S_ST_BYTE;
                                r_wr    <= 1'b1;
                                r_dm_a  <= req_addr;
                                r_dm_wd <= {24'h0, req_wdata[7:0]};
                                r_dm_f3 <= F3_B;
                            end
                        end
                    end
                end
                S_LD_LO: begin
                    r_lo <= dm_rd;
                    if (r_mis) begin
                        r_state <= S_LD_HI;
                        r_dm_a  <= w_cw1;
                    end else begin
                        r_state     <= S_IDLE;
                        r_rd        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_ld_res;
                    end
                end
                S_LD_HI: begin
                    r_hi        <= dm_rd;
                    r_state     <= S_IDLE;
                    r_rd        <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= w_ld_res;
                end
                S_ST_ALN: begin
                    r_state     <= S_IDLE;
                    r_wr        <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= '0;
                end
                S_ST_BYTE: begin
                    if (r_k == w_k_last) begin
                        r_state     <= S_IDLE;
                        r_wr        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_k     <= w_k_next;
                        r_dm_a  <= w_byte_addr;
                        r_dm_wd <= {24'h0, w_byte};
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: byte-array datamemory model,
// directed vector table, reset-abort sequence and random requests.
module tb_mem_access_sequencer;

    localparam int DM = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [DM-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          dm_MemRead;
    logic          dm_MemWrite;
    logic [DM-1:0] dm_a;
    logic [31:0]   dm_wd;
    logic [2:0]    dm_Funct3;
    logic [31:0]   dm_rd;

    always #5 clk = ~clk;

    mem_access_sequencer #(.DM_ADDRESS(DM), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite),
        .dm_a(dm_a), .dm_wd(dm_wd), .dm_Funct3(dm_Funct3), .dm_rd(dm_rd)
    );

    typedef struct {
        bit       wr;
        logic [8:0] a;
    } acc_t;

    typedef struct {
        bit          wr;
        logic [2:0]  f3;
        logic [8:0]  addr;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          err;
        int          lat;
    } vec_t;

    logic [7:0] mem [0:511] = '{default: 8'h00};
    logic [7:0] em  [0:511];
    logic [7:0] snap [0:3];
    acc_t       acc_q [$];
    acc_t       exp_q [$];
    vec_t       tbl [20];
    int         checks = 0;
    int         errors = 0;
    int         overlap = 0;
    int         exp_lat;
    bit         exp_err;
    logic [31:0] exp_rd;

    always_comb begin
        dm_rd = {mem[9'(dm_a + 9'd3)], mem[9'(dm_a + 9'd2)],
                 mem[9'(dm_a + 9'd1)], mem[dm_a]};
    end

    // Datamemory commits writes on the falling edge.
    always @(negedge clk) begin
        if (dm_MemRead && dm_MemWrite) overlap++;
        if (dm_MemRead || dm_MemWrite) acc_q.push_back('{dm_MemWrite, dm_a});
        if (dm_MemWrite) begin
            case (dm_Funct3)
                3'b000: mem[dm_a] = dm_wd[7:0];
                3'b001: begin
                    mem[dm_a] = dm_wd[7:0];
                    mem[9'(dm_a + 9'd1)] = dm_wd[15:8];
                end
                3'b010: begin
                    for (int i = 0; i < 4; i++)
                        mem[9'(dm_a + 9'(i))] = dm_wd[8*i +: 8];
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic model(input bit wr, input logic [2:0] f3,
                         input logic [8:0] addr, input logic [31:0] wd);
        int          size;
        bit          mis;
        logic [31:0] v;
        logic [8:0]  w0;
        for (int i = 0; i < 512; i++) em[i] = mem[i];
        exp_q.delete();
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        exp_err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
               || (wr && f3[2]);
        mis = (int'(addr) % size) != 0;
        exp_rd = '0;
        exp_lat = 1;
        if (exp_err) return;
        w0 = addr & 9'h1FC;
        if (!wr) begin
            v = '0;
            for (int i = 0; i < size; i++)
                v = v | (32'(mem[9'(addr + 9'(i))]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1])
                v = v | (32'hFFFF_FFFF << (8 * size));
            exp_rd = v;
            exp_lat = mis ? 3 : 2;
            exp_q.push_back('{1'b0, w0});
            if (mis) exp_q.push_back('{1'b0, 9'(w0 + 9'd4)});
        end else begin
            for (int i = 0; i < size; i++)
                em[9'(addr + 9'(i))] = wd[8*i +: 8];
            exp_lat = !mis ? 2 : (size == 2 ? 3 : 5);
            if (!mis) exp_q.push_back('{1'b1, addr});
            else for (int i = 0; i < size; i++)
                exp_q.push_back('{1'b1, 9'(addr + 9'(i))});
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at the
    // falling edge of the response cycle.
    task automatic issue(input bit wr, input logic [2:0] f3,
                         input logic [8:0] addr, input logic [31:0] wd,
                         output int lat, output bit err,
                         output logic [31:0] rd);
        chk("ready_at_issue", {31'b0, req_ready}, 32'd1);
        acc_q.delete();
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1;
        err = 1'b0;
        rd  = 'x;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = c;
                err = rsp_err;
                rd  = rsp_rdata;
                break;
            end
        end
    endtask

    task automatic check_all(input string tag, input int lat, input bit err,
                             input logic [31:0] rd, input int elat,
                             input bit eerr, input logic [31:0] erd);
        int bad;
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".err"}, {31'b0, err}, {31'b0, eerr});
        if (!eerr) chk({tag, ".rdata"}, rd, erd);
        chk({tag, ".n_access"}, acc_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
            if (acc_q[i].wr !== exp_q[i].wr || acc_q[i].a !== exp_q[i].a)
                bad++;
        chk({tag, ".access_seq"}, bad, 0);
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== em[i]) bad++;
        chk({tag, ".mem_bytes_wrong"}, bad, 0);
    endtask

    initial begin
        int          lat;
        bit          err;
        logic [31:0] rd;
        int          seen;
        bit          wr;
        logic [2:0]  f3;
        logic [8:0]  ad;
        logic [31:0] wd;

        tbl[0]  = '{1, 3'b010, 9'h010, 32'h8899AABB, 32'h0, 0, 2};
        tbl[1]  = '{0, 3'b010, 9'h010, 32'h0, 32'h8899AABB, 0, 2};
        tbl[2]  = '{1, 3'b010, 9'h010, 32'h44332211, 32'h0, 0, 2};
        tbl[3]  = '{1, 3'b010, 9'h014, 32'h88776655, 32'h0, 0, 2};
        tbl[4]  = '{0, 3'b010, 9'h013, 32'h0, 32'h77665544, 0, 3};
        tbl[5]  = '{0, 3'b001, 9'h013, 32'h0, 32'h00005544, 0, 3};
        tbl[6]  = '{0, 3'b000, 9'h017, 32'h0, 32'hFFFFFF88, 0, 2};
        tbl[7]  = '{0, 3'b101, 9'h016, 32'h0, 32'h00008877, 0, 2};
        tbl[8]  = '{1, 3'b010, 9'h1FE, 32'hDEADBEEF, 32'h0, 0, 5};
        tbl[9]  = '{0, 3'b101, 9'h000, 32'h0, 32'h0000DEAD, 0, 2};
        tbl[10] = '{0, 3'b010, 9'h1FD, 32'h0, 32'hADBEEF00, 0, 3};
        tbl[11] = '{0, 3'b011, 9'h020, 32'h0, 32'h0, 1, 1};
        tbl[12] = '{1, 3'b100, 9'h020, 32'h55, 32'h0, 1, 1};
        tbl[13] = '{1, 3'b001, 9'h021, 32'h0000CAFE, 32'h0, 0, 3};
        tbl[14] = '{0, 3'b101, 9'h021, 32'h0, 32'h0000CAFE, 0, 3};
        tbl[15] = '{0, 3'b100, 9'h022, 32'h0, 32'h000000CA, 0, 2};
        tbl[16] = '{1, 3'b000, 9'h1FF, 32'hABCDEF77, 32'h0, 0, 2};
        tbl[17] = '{0, 3'b000, 9'h1FF, 32'h0, 32'h00000077, 0, 2};
        tbl[18] = '{1, 3'b001, 9'h024, 32'h1234ABCD, 32'h0, 0, 2};
        tbl[19] = '{0, 3'b001, 9'h024, 32'h0, 32'hFFFFABCD, 0, 2};

        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = '0;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset.req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset.rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("reset.rsp_rdata", rsp_rdata, 32'd0);
        chk("reset.strobes", {30'b0, dm_MemRead, dm_MemWrite}, 32'd0);
        chk("reset.dm_a", {23'b0, dm_a}, 32'd0);
        chk("reset.dm_wd", dm_wd, 32'd0);
        chk("reset.dm_Funct3", {29'b0, dm_Funct3}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            model(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd);
            issue(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, lat, err, rd);
            check_all($sformatf("vec%0d", i), lat, err, rd,
                      tbl[i].lat, tbl[i].err, tbl[i].rd);
        end

        // Abort a misaligned SW during its second byte write.
        for (int i = 0; i < 4; i++) snap[i] = mem[9'h041 + 9'(i)];
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 9'h041;
        req_wdata  = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.strobes", {30'b0, dm_MemRead, dm_MemWrite}, 32'd0);
        chk("abort.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort.req_ready", {31'b0, req_ready}, 32'd1);
        reset = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || dm_MemRead || dm_MemWrite) seen++;
        end
        chk("abort.quiet_after", seen, 0);
        chk("abort.byte0", {24'b0, mem[9'h041]}, 32'h44);
        chk("abort.byte1", {24'b0, mem[9'h042]}, 32'h33);
        chk("abort.byte2", {24'b0, mem[9'h043]}, {24'b0, snap[2]});
        chk("abort.byte3", {24'b0, mem[9'h044]}, {24'b0, snap[3]});

        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            ad = 9'($urandom_range(0, 511));
            wd = $urandom;
            model(wr, f3, ad, wd);
            issue(wr, f3, ad, wd, lat, err, rd);
            check_all($sformatf("rnd%0d", i), lat, err, rd,
                      exp_lat, exp_err, exp_rd);
        end

        chk("read_write_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
